// File: rtl/axi_lite_write_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-lite write master.
// One transaction outstanding at a time; per-requester completion counters.
`timescale 1ns/1ps
module axi_lite_write_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  input  logic [31:0]      r0_addr,
  input  logic [31:0]      r0_data,
  output logic             r0_ack,
  output logic [1:0]       r0_err,
  input  logic             r1_valid,
  input  logic [31:0]      r1_addr,
  input  logic [31:0]      r1_data,
  output logic             r1_ack,
  output logic [1:0]       r1_err,
  output logic             m_write_valid,
  output logic [31:0]      m_write_addr,
  output logic [31:0]      m_write_data,
  input  logic             m_write_ack,
  input  logic [1:0]       m_write_err,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] r0_count,
  output logic [CNT_W-1:0] r1_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             m_write_valid_q, m_write_valid_d;
  logic [31:0]      m_write_addr_q, m_write_addr_d;
  logic [31:0]      m_write_data_q, m_write_data_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic             r0_ack_q, r0_ack_d;
  logic             r1_ack_q, r1_ack_d;
  logic [1:0]       r0_err_q, r0_err_d;
  logic [1:0]       r1_err_q, r1_err_d;
  logic [CNT_W-1:0] r0_count_q, r0_count_d;
  logic [CNT_W-1:0] r1_count_q, r1_count_d;
  logic             busy_q, busy_d;
  logic             r0_elig;
  logic             r1_elig;
  logic             winner;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A requester whose ack is high this cycle is still holding valid; mask it.
  assign r0_elig = r0_valid & ~r0_ack_q;
  assign r1_elig = r1_valid & ~r1_ack_q;

  // Next-state, arbitration and completion bookkeeping.
  always_comb begin
    state_d         = state_q;
    m_write_valid_d = m_write_valid_q;
    m_write_addr_d  = m_write_addr_q;
    m_write_data_d  = m_write_data_q;
    grant_id_d      = grant_id_q;
    last_grant_d    = last_grant_q;
    r0_ack_d        = 1'b0;
    r1_ack_d        = 1'b0;
    r0_err_d        = r0_err_q;
    r1_err_d        = r1_err_q;
    r0_count_d      = r0_count_q;
    r1_count_d      = r1_count_q;
    winner          = 1'b0;
    case (state_q)
      IDLE: begin
        if (r0_elig && r1_elig) begin
          winner = ~last_grant_q;
        end else if (r1_elig) begin
          winner = 1'b1;
        end else begin
          winner = 1'b0;
        end
        if (r0_elig || r1_elig) begin
          m_write_addr_d  = winner ? r1_addr : r0_addr;
          m_write_data_d  = winner ? r1_data : r0_data;
          grant_id_d      = winner;
          m_write_valid_d = 1'b1;
          state_d         = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        m_write_valid_d = 1'b0;
        state_d         = WAIT;
      end
      WAIT: begin
        if (m_write_ack) begin
          if (grant_id_q) begin
            r1_ack_d   = 1'b1;
            r1_err_d   = m_write_err;
            r1_count_d = r1_count_q + CNT_ONE;
          end else begin
            r0_ack_d   = 1'b1;
            r0_err_d   = m_write_err;
            r0_count_d = r0_count_q + CNT_ONE;
          end
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        m_write_valid_d = 1'b0;
        state_d         = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      m_write_valid_q <= 1'b0;
      m_write_addr_q  <= 32'h0000_0000;
      m_write_data_q  <= 32'h0000_0000;
      grant_id_q      <= 1'b0;
      last_grant_q    <= 1'b1;
      r0_ack_q        <= 1'b0;
      r1_ack_q        <= 1'b0;
      r0_err_q        <= 2'b00;
      r1_err_q        <= 2'b00;
      r0_count_q      <= {CNT_W{1'b0}};
      r1_count_q      <= {CNT_W{1'b0}};
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      m_write_valid_q <= m_write_valid_d;
      m_write_addr_q  <= m_write_addr_d;
      m_write_data_q  <= m_write_data_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      r0_ack_q        <= r0_ack_d;
      r1_ack_q        <= r1_ack_d;
      r0_err_q        <= r0_err_d;
      r1_err_q        <= r1_err_d;
      r0_count_q      <= r0_count_d;
      r1_count_q      <= r1_count_d;
      busy_q          <= busy_d;
    end
  end

  assign m_write_valid = m_write_valid_q;
  assign m_write_addr  = m_write_addr_q;
  assign m_write_data  = m_write_data_q;
  assign grant_id      = grant_id_q;
  assign r0_ack        = r0_ack_q;
  assign r1_ack        = r1_ack_q;
  assign r0_err        = r0_err_q;
  assign r1_err        = r1_err_q;
  assign r0_count      = r0_count_q;
  assign r1_count      = r1_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Bench for axi_lite_write_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_axi_lite_write_arbiter;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             r0_valid, r1_valid, r0_ack, r1_ack;
  logic [31:0]      r0_addr, r0_data, r1_addr, r1_data;
  logic [1:0]       r0_err, r1_err;
  logic             m_write_valid, m_write_ack, busy, grant_id;
  logic [31:0]      m_write_addr, m_write_data;
  logic [1:0]       m_write_err;
  logic [CNT_W-1:0] r0_count, r1_count;

  int n_cmp = 0;
  int n_fail = 0;

  bit         stub_en = 1'b0;
  int         stub_delay = 0;
  int         stub_cd = 0;
  logic [1:0] stub_err0 = 2'b00;
  logic [1:0] stub_err1 = 2'b00;

  axi_lite_write_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ack(r0_ack), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ack(r1_ack), .r1_err(r1_err),
    .m_write_valid(m_write_valid), .m_write_addr(m_write_addr), .m_write_data(m_write_data),
    .m_write_ack(m_write_ack), .m_write_err(m_write_err),
    .busy(busy), .grant_id(grant_id), .r0_count(r0_count), .r1_count(r1_count)
  );

  always #5 clk = ~clk;

  // Write-master stub: acks stub_delay+1 cycles after the cycle m_write_valid is seen.
  always @(posedge clk) begin
    #1;
    if (stub_en) begin
      m_write_ack = 1'b0;
      if (m_write_valid) begin
        stub_cd = stub_delay + 1;
      end else if (stub_cd > 0) begin
        stub_cd = stub_cd - 1;
        if (stub_cd == 0) begin
          m_write_ack = 1'b1;
          m_write_err = grant_id ? stub_err1 : stub_err0;
        end
      end
    end else begin
      stub_cd = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stub_en = 1'b0;
    stub_delay = 0;
    stub_err0 = 2'b00;
    stub_err1 = 2'b00;
    m_write_ack = 1'b0;
    m_write_err = 2'b00;
    r0_valid = 1'b0; r0_addr = 32'h0; r0_data = 32'h0;
    r1_valid = 1'b0; r1_addr = 32'h0; r1_data = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [88:0] obs;
    r0_valid = 1'b0; r1_valid = 1'b0; m_write_ack = 1'b0; m_write_err = 2'b00;
    r0_addr = 32'h0; r0_data = 32'h0; r1_addr = 32'h0; r1_data = 32'h0;
    #2 reset = 1'b1;
    #1;
    obs = {m_write_valid, m_write_addr, m_write_data, r0_ack, r1_ack, r0_err, r1_err,
           r0_count, r1_count, busy, grant_id};
    n_cmp++;
    if (obs !== 89'h0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", obs); end
    tick();
    obs = {m_write_valid, m_write_addr, m_write_data, r0_ack, r1_ack, r0_err, r1_err,
           r0_count, r1_count, busy, grant_id};
    n_cmp++;
    if (obs !== 89'h0) begin n_fail++; $display("FAIL reset_held: got %h expected 0", obs); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    r0_addr = 32'h0000_0010; r0_data = 32'hA5A5_A5A5; r0_valid = 1'b1;
    stub_delay = 2; stub_err0 = 2'b00; stub_en = 1'b1;
    tick();
    n_cmp++;
    if ({m_write_valid, busy, grant_id} !== 3'b110) begin
      n_fail++; $display("FAIL single_issue: got %b expected 110", {m_write_valid, busy, grant_id});
    end
    n_cmp++;
    if ({m_write_addr, m_write_data} !== {32'h0000_0010, 32'hA5A5_A5A5}) begin
      n_fail++; $display("FAIL single_addr_data: got %h %h expected 10 a5a5a5a5", m_write_addr, m_write_data);
    end
    tick();
    n_cmp++;
    if (m_write_valid !== 1'b0 || m_write_addr !== 32'h10) begin
      n_fail++; $display("FAIL single_one_cycle_valid: got valid %b addr %h expected 0 10", m_write_valid, m_write_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (r0_ack !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: got %b expected 0", r0_ack); end
    tick();
    n_cmp++;
    if ({r0_ack, r1_ack, r0_err, r0_count, busy} !== {1'b1, 1'b0, 2'b00, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL single_ack: got ack %b/%b err %b cnt %0d busy %b expected 1/0 00 1 0",
                         r0_ack, r1_ack, r0_err, r0_count, busy);
    end
    tick();
    r0_valid = 1'b0;
    n_cmp++;
    if ({m_write_valid, r0_ack, r0_count} !== {1'b0, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL single_no_reissue: got valid %b ack %b cnt %0d expected 0 0 1",
                         m_write_valid, r0_ack, r0_count);
    end
  endtask

  task automatic test_contention();
    int order[3];
    int exp_order[3] = '{0, 1, 0};
    int ng = 0, a0 = 0, a1 = 0;
    bit d0 = 1'b0, rs0 = 1'b0, d1 = 1'b0, overlap = 1'b0, done = 1'b0;
    do_reset();
    r0_addr = 32'h0000_0100; r0_data = 32'h0000_0001;
    r1_addr = 32'h0000_0200; r1_data = 32'h0000_0011;
    r0_valid = 1'b1; r1_valid = 1'b1;
    stub_delay = 0; stub_en = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (rs0) begin r0_valid = 1'b1; r0_data = 32'h0000_0002; rs0 = 1'b0; end
      if (d0) begin r0_valid = 1'b0; d0 = 1'b0; rs0 = (a0 == 1); end
      if (d1) begin r1_valid = 1'b0; d1 = 1'b0; end
      if (m_write_valid && ng < 3) begin order[ng] = int'(grant_id); ng++; end
      if (r0_ack && r1_ack) overlap = 1'b1;
      if (r0_ack) begin a0++; d0 = 1'b1; end
      if (r1_ack) begin a1++; d1 = 1'b1; end
      done = (a0 + a1 == 3);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    n_cmp++;
    if (!done || ng != 3) begin n_fail++; $display("FAIL contention_timeout: got %0d grants %0d acks expected 3 3", ng, a0 + a1); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i < ng && order[i] != exp_order[i]) begin
        n_fail++; $display("FAIL contention_order[%0d]: got r%0d expected r%0d", i, order[i], exp_order[i]);
      end
    end
    n_cmp++;
    if ({r0_count, r1_count, overlap} !== {8'd2, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL contention_counts: got %0d %0d overlap %b expected 2 1 0", r0_count, r1_count, overlap);
    end
    tick();
    stub_en = 1'b0;
  endtask

  task automatic test_error();
    bit seen = 1'b0, bad0 = 1'b0;
    do_reset();
    r1_addr = 32'h0000_0300; r1_data = 32'hDEAD_BEEF; r1_valid = 1'b1;
    stub_err0 = 2'b01; stub_err1 = 2'b10; stub_delay = 1; stub_en = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (r0_ack) bad0 = 1'b1;
      if (r1_ack) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || r1_err !== 2'b10 || r0_err !== 2'b00) begin
      n_fail++; $display("FAIL error_resp: got seen %b r1_err %b r0_err %b expected 1 10 00", seen, r1_err, r0_err);
    end
    tick();
    r1_valid = 1'b0;
    tick();
    if (r0_ack) bad0 = 1'b1;
    n_cmp++;
    if ({r1_err, r1_ack, r1_count, r0_count, bad0} !== {2'b10, 1'b0, 8'd1, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL error_hold: got err %b ack %b cnt %0d/%0d bad0 %b expected 10 0 1/0 0",
                         r1_err, r1_ack, r1_count, r0_count, bad0);
    end
    stub_en = 1'b0;
  endtask

  task automatic test_wrap();
    int pulses = 0;
    int extra = 0;
    do_reset();
    r0_addr = 32'h0000_0400; r0_data = 32'h1234_5678; r0_valid = 1'b1;
    stub_delay = 0; stub_en = 1'b1;
    for (int c = 0; c < 3000 && pulses < 256; c++) begin
      tick();
      if (r0_ack) begin
        pulses++;
        if (pulses == 255) begin
          n_cmp++;
          if (r0_count !== 8'hFF) begin n_fail++; $display("FAIL wrap_all_ones: got %h expected ff", r0_count); end
        end
      end
    end
    r0_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (r0_ack || m_write_valid) extra++;
    end
    n_cmp++;
    if (pulses != 256 || extra != 0 || r0_count !== 8'h00 || r1_count !== 8'h00) begin
      n_fail++; $display("FAIL wrap: got pulses %0d extra %0d cnt %h/%h expected 256 0 00/00",
                         pulses, extra, r0_count, r1_count);
    end
    stub_en = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [88:0] obs;
    bit stray = 1'b0;
    do_reset();
    r0_addr = 32'h0000_0500; r0_data = 32'hCAFE_F00D; r0_valid = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midwait_busy: got %b expected 1", busy); end
    #2 reset = 1'b1;
    r0_valid = 1'b0;
    #1;
    obs = {m_write_valid, m_write_addr, m_write_data, r0_ack, r1_ack, r0_err, r1_err,
           r0_count, r1_count, busy, grant_id};
    n_cmp++;
    if (obs !== 89'h0) begin n_fail++; $display("FAIL midwait_reset: got %h expected 0", obs); end
    tick();
    reset = 1'b0;
    m_write_ack = 1'b1; m_write_err = 2'b11;
    tick();
    m_write_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (r0_ack || r1_ack) stray = 1'b1;
    end
    n_cmp++;
    if ({stray, r0_count, r0_err, busy} !== {1'b0, 8'd0, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL midwait_no_ack: got ack %b cnt %0d err %b busy %b expected 0 0 00 0",
                         stray, r0_count, r0_err, busy);
    end
  endtask

  task automatic test_stray_ack();
    bit any = 1'b0;
    do_reset();
    tick();
    m_write_ack = 1'b1; m_write_err = 2'b11;
    tick();
    m_write_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (r0_ack || r1_ack) any = 1'b1;
    end
    n_cmp++;
    if ({any, r0_count, r1_count, r0_err, r1_err, busy} !== {1'b0, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL stray_ack: got ack %b cnt %0d/%0d err %b/%b busy %b expected 0 0/0 00/00 0",
                         any, r0_count, r1_count, r0_err, r1_err, busy);
    end
  endtask

  task automatic test_random();
    bit rv[2], drop_nx[2], wait_ack[2], ack_now[2], elig[2], ea[2];
    logic [31:0] ra[2], rd[2];
    logic [CNT_W-1:0] mcnt[2];
    logic [1:0] merr[2];
    bit mo, mfresh, mwin, mlast, ev, ewin, ack_in;
    logic [31:0] eaddr, edata;
    logic [1:0] err_in;
    logic [4:0] obs_h, exp_h;
    logic [83:0] obs_d, exp_d;
    int cd = 0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; drop_nx[i] = 1'b0; wait_ack[i] = 1'b0; ea[i] = 1'b0;
      ra[i] = 32'h0; rd[i] = 32'h0; mcnt[i] = 8'd0; merr[i] = 2'b00;
    end
    mo = 1'b0; mfresh = 1'b0; mwin = 1'b0; mlast = 1'b1; ev = 1'b0; ewin = 1'b0;
    eaddr = 32'h0; edata = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      obs_h = {m_write_valid, r0_ack, r1_ack, busy, grant_id};
      exp_h = {ev, ea[0], ea[1], mo, ewin};
      n_cmp++;
      if (obs_h !== exp_h) begin n_fail++; $display("FAIL rand_handshake cyc %0d: got %b expected %b", cyc, obs_h, exp_h); end
      obs_d = {m_write_addr, m_write_data, r0_err, r1_err, r0_count, r1_count};
      exp_d = {eaddr, edata, merr[0], merr[1], mcnt[0], mcnt[1]};
      n_cmp++;
      if (obs_d !== exp_d) begin n_fail++; $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, obs_d, exp_d); end
      ack_now = ea;
      // Requesters hold valid until their ack, drop it the cycle after, or abandon early.
      for (int i = 0; i < 2; i++) begin
        if (ack_now[i]) begin
          drop_nx[i] = rv[i]; wait_ack[i] = 1'b0;
        end else if (drop_nx[i]) begin
          rv[i] = 1'b0; drop_nx[i] = 1'b0;
        end else if (!rv[i] && !wait_ack[i]) begin
          if ($urandom_range(0, 2) == 0) begin rv[i] = 1'b1; ra[i] = $urandom; rd[i] = $urandom; end
        end else if (rv[i] && wait_ack[i] && $urandom_range(0, 7) == 0) begin
          rv[i] = 1'b0;
        end
      end
      ack_in = 1'b0;
      err_in = 2'($urandom_range(0, 3));
      if (mo && !mfresh) begin
        if (cd == 0) ack_in = 1'b1;
        else cd--;
      end else if ($urandom_range(0, 5) == 0) begin
        ack_in = 1'b1;
      end
      r0_valid = rv[0]; r0_addr = ra[0]; r0_data = rd[0];
      r1_valid = rv[1]; r1_addr = ra[1]; r1_data = rd[1];
      m_write_ack = ack_in; m_write_err = err_in;
      ea[0] = 1'b0; ea[1] = 1'b0; ev = 1'b0;
      for (int i = 0; i < 2; i++) elig[i] = rv[i] && !ack_now[i];
      if (mo && !mfresh && ack_in) begin
        ea[mwin] = 1'b1; merr[mwin] = err_in; mcnt[mwin] = mcnt[mwin] + 8'd1;
        mlast = mwin; mo = 1'b0;
      end else if (!mo && (elig[0] || elig[1])) begin
        mwin = (elig[0] && elig[1]) ? !mlast : elig[1];
        mo = 1'b1; mfresh = 1'b1; ev = 1'b1; ewin = mwin;
        eaddr = ra[mwin]; edata = rd[mwin]; wait_ack[mwin] = 1'b1;
        cd = $urandom_range(0, 3);
      end else begin
        mfresh = 1'b0;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0; m_write_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_error();
    test_wrap();
    test_reset_mid_wait();
    test_stray_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
